// File: rtl/mips_cpu_fetch_unit.sv
// MIPS instruction fetch unit.
// Issues word reads over an Avalon-style read interface, hands each returned
// word and its address to the decode path through a valid/ready handshake,
// and owns the fetch PC (sequential, redirected, or halted on next PC of 0).
module mips_cpu_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    HALTED
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] pending_pc;
  logic        pending;
  logic [31:0] redirect_aligned;
  logic [31:0] next_pc;

  // The request address is the fetch PC itself; it only moves on accept, so
  // it is naturally stable while the slave stalls.
  assign mem_address      = fetch_pc;
  assign mem_byteenable   = mem_read ? 4'b1111 : 4'b0000;
  assign redirect_aligned = {redirect_pc[31:2], 2'b00};

  // Next fetch address: a same-cycle redirect beats a stored one, which beats
  // the sequential increment.
  always_comb begin
    // NOTE: assign a default before any branch so the combinational block can
    // never hold a stale value (no latch is inferred).
    next_pc = fetch_pc + 32'd4;
    if (redirect) begin
      next_pc = redirect_aligned;
    end else if (pending) begin
      next_pc = pending_pc;
    end
  end

  // Fetch FSM with registered bus and instruction outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state       <= IDLE;
      fetch_pc    <= RESET_VECTOR;
      pending_pc  <= 32'd0;
      pending     <= 1'b0;
      mem_read    <= 1'b0;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect) begin
            pending_pc <= redirect_aligned;
            pending    <= 1'b1;
          end
          if (enable) begin
            state    <= FETCH;
            mem_read <= 1'b1;
          end
        end

        FETCH: begin
          // A redirect here is remembered; the word in flight is the delay slot.
          if (redirect) begin
            pending_pc <= redirect_aligned;
            pending    <= 1'b1;
          end
          if (!mem_waitrequest) begin
            instr       <= mem_readdata;
            instr_pc    <= fetch_pc;
            instr_valid <= 1'b1;
            mem_read    <= 1'b0;
            state       <= HOLD;
          end
        end

        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            fetch_pc    <= next_pc;
            pending     <= 1'b0;
            if (next_pc == 32'd0) begin
              halted <= 1'b1;
              state  <= HALTED;
            end else if (enable) begin
              mem_read <= 1'b1;
              state    <= FETCH;
            end else begin
              state <= IDLE;
            end
          end else if (redirect) begin
            pending_pc <= redirect_aligned;
            pending    <= 1'b1;
          end
        end

        HALTED: begin
          // Sticky until reset.
          halted <= 1'b1;
        end

        default: begin
          state    <= IDLE;
          mem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_fetch_unit.sv
// Self-checking bench for mips_cpu_fetch_unit. A behavioural memory returns
// address ^ 32'h5A5A5A5A; expected words are queued when a fetch is observed
// and compared when the unit presents the instruction.
module tb_mips_cpu_fetch_unit;

  localparam logic [31:0] RV  = 32'hBFC00000;
  localparam logic [31:0] KEY = 32'h5A5A5A5A;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic        mem_waitrequest;
  logic [31:0] mem_readdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  mips_cpu_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_byteenable  (mem_byteenable),
    .mem_waitrequest (mem_waitrequest),
    .mem_readdata    (mem_readdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .halted          (halted)
  );

  // Memory model: data is only meaningful when the slave is not stalling.
  assign mem_readdata = mem_waitrequest ? 32'hDEADBEEF : (mem_address ^ KEY);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    mem_waitrequest = 1'b0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One complete fetch: wait for the request, stall it wait_n cycles, then
  // hold the instruction hold_n cycles before accepting it.
  task automatic run_fetch(input logic [31:0] exp_addr, input int wait_n, input int hold_n,
                           input logic rd_fetch, input logic rd_hold, input logic [31:0] rd_pc);
    int   n;
    exp_t e;
    n = 0;
    while (mem_read !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (mem_read !== 1'b1) begin
      bad++;
      $display("FAIL fetch_start: mem_read=%b required 1 for addr %h", mem_read, exp_addr);
      return;
    end
    total++;
    if (mem_address !== exp_addr) begin
      bad++;
      $display("FAIL fetch_addr: got %h required %h", mem_address, exp_addr);
    end
    total++;
    if (mem_byteenable !== 4'b1111) begin
      bad++;
      $display("FAIL byteenable: got %b required 1111", mem_byteenable);
    end
    sb.push_back('{pc: exp_addr, word: exp_addr ^ KEY});

    mem_waitrequest = (wait_n > 0);
    redirect        = rd_fetch;
    redirect_pc     = rd_pc;
    for (int i = 0; i < wait_n; i++) begin
      tick();
      redirect = 1'b0;
      total++;
      if (mem_read !== 1'b1 || mem_address !== exp_addr || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait_hold: read=%b addr=%h valid=%b required 1/%h/0",
                 mem_read, mem_address, instr_valid, exp_addr);
      end
      if (i == wait_n - 1) mem_waitrequest = 1'b0;
    end
    tick();
    redirect = 1'b0;

    total++;
    if (instr_valid !== 1'b1 || mem_read !== 1'b0) begin
      bad++;
      $display("FAIL hold_enter: valid=%b read=%b required 1/0", instr_valid, mem_read);
    end
    e = sb.pop_front();
    total++;
    if (instr !== e.word) begin
      bad++;
      $display("FAIL instr: got %h required %h", instr, e.word);
    end
    total++;
    if (instr_pc !== e.pc) begin
      bad++;
      $display("FAIL instr_pc: got %h required %h", instr_pc, e.pc);
    end

    instr_ready = (hold_n == 0);
    redirect    = rd_hold && (hold_n == 0);
    for (int i = 0; i < hold_n; i++) begin
      tick();
      total++;
      if (instr !== e.word || instr_pc !== e.pc || instr_valid !== 1'b1 || mem_read !== 1'b0) begin
        bad++;
        $display("FAIL ready_stall: instr=%h pc=%h valid=%b read=%b required %h/%h/1/0",
                 instr, instr_pc, instr_valid, mem_read, e.word, e.pc);
      end
      if (i == hold_n - 1) begin
        instr_ready = 1'b1;
        redirect    = rd_hold;
      end
    end
    tick();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL accept: instr_valid=%b required 0", instr_valid);
    end
  endtask

  task automatic test_reset();
    enable = 1'b0;
    pulse_reset();
    total++;
    if (mem_read !== 1'b0 || mem_address !== RV || mem_byteenable !== 4'b0000) begin
      bad++;
      $display("FAIL reset_bus: read=%b addr=%h be=%b required 0/%h/0000",
               mem_read, mem_address, mem_byteenable, RV);
    end
    total++;
    if (instr !== 32'd0 || instr_pc !== 32'd0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_instr: instr=%h pc=%h valid=%b halted=%b required 0/0/0/0",
               instr, instr_pc, instr_valid, halted);
    end
    repeat (3) tick();
    total++;
    if (mem_read !== 1'b0) begin
      bad++;
      $display("FAIL idle_disabled: mem_read=%b required 0", mem_read);
    end
  endtask

  task automatic test_sequential();
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_fetch(RV + 32'(4 * k), 0, 0, 1'b0, 1'b0, 32'd0);
      total++;
      if (mem_read !== 1'b1) begin
        bad++;
        $display("FAIL back_to_back: mem_read=%b required 1 after accept %0d", mem_read, k);
      end
    end
  endtask

  task automatic test_waitrequest();
    run_fetch(RV + 32'h0C, 3, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_ready_stall();
    run_fetch(RV + 32'h10, 0, 4, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_redirect();
    pulse_reset();
    run_fetch(RV, 0, 0, 1'b0, 1'b0, 32'd0);
    run_fetch(RV + 32'h4, 1, 0, 1'b1, 1'b0, 32'h00400013);
    run_fetch(32'h00400010, 0, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_idle_redirect();
    // Dropping enable mid-fetch must not cancel the request in flight.
    enable = 1'b0;
    run_fetch(32'h00400014, 0, 0, 1'b0, 1'b0, 32'd0);
    repeat (3) tick();
    total++;
    if (mem_read !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: mem_read=%b required 0", mem_read);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h00400103;
    tick();
    redirect = 1'b0;
    tick();
    total++;
    if (mem_read !== 1'b0 || mem_address !== 32'h00400018) begin
      bad++;
      $display("FAIL idle_redirect: read=%b addr=%h required 0/00400018", mem_read, mem_address);
    end
    enable = 1'b1;
    run_fetch(32'h00400018, 0, 0, 1'b0, 1'b0, 32'd0);
    run_fetch(32'h00400100, 0, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_halt();
    int bad_cycles;
    run_fetch(32'h00400104, 0, 0, 1'b0, 1'b1, 32'h00000000);
    total++;
    if (halted !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'd0) begin
      bad++;
      $display("FAIL halt_enter: halted=%b read=%b addr=%h required 1/0/0", halted, mem_read, mem_address);
    end
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_read !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) bad_cycles++;
    end
    total++;
    if (bad_cycles != 0) begin
      bad++;
      $display("FAIL halt_sticky: %0d bad cycles, required 0", bad_cycles);
    end
    pulse_reset();
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset: halted=%b required 0", halted);
    end
    run_fetch(RV, 0, 0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_mid();
    // The unit is now requesting RV+4; stall it and reset between edges.
    mem_waitrequest = 1'b1;
    tick();
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b0 || instr_valid !== 1'b0 || mem_address !== RV) begin
      bad++;
      $display("FAIL async_reset: read=%b valid=%b addr=%h required 0/0/%h",
               mem_read, instr_valid, mem_address, RV);
    end
    @(negedge clk);
    mem_waitrequest = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_fetch(RV, 0, 0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    enable          = 1'b0;
    mem_waitrequest = 1'b0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = 32'd0;

    test_reset();
    test_sequential();
    test_waitrequest();
    test_ready_stall();
    test_redirect();
    test_idle_redirect();
    test_halt();
    test_reset_mid();

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
